fo4_meas: RTL

FO4_MEAS -- requirements
Module: fo4_meas

---
 rtl/fo4_meas_pkg.sv | 7 +
 rtl/fo4_meas_sync.sv | 15 +
 rtl/fo4_meas.sv | 111 +++++++++++
 3 files changed

// File: rtl/fo4_meas_pkg.sv
// fo4_meas_pkg: FSM state encoding and default parameters shared by the FO4 measurement block.
package fo4_meas_pkg;
  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_e;
  localparam int WINDOW_W_DEF = 16;
  localparam int CNT_W_DEF = 16;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/fo4_meas_sync.sv
// fo4_meas_sync: multi-flop synchronizer with rising-edge detect on the synchronized level.
module fo4_meas_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d,
  output logic rise
);
  logic [STAGES:0] sr;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) sr <= '0;
    else sr <= {sr[STAGES-1:0], d};
  assign rise = sr[STAGES-1] & ~sr[STAGES];
endmodule

// File: rtl/fo4_meas.sv
// fo4_meas: gated ring-oscillator edge counter; FO4_MEAS_DELAY_EN adds a probe_in->probe_out delay_o.
module fo4_meas
  import fo4_meas_pkg::*;
#(
  parameter int WINDOW_W = WINDOW_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic [WINDOW_W-1:0] window_i,
  input  logic                probe_in_i,
  input  logic                probe_out_i,
  output logic [CNT_W-1:0]    result_o,
  output logic                overflow_o,
  output logic                v_o,
  input  logic                yumi_i
`ifdef FO4_MEAS_DELAY_EN
  ,
  output logic [CNT_W-1:0]    delay_o
`endif
);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [WINDOW_W-1:0] WONE = WINDOW_W'(1);
  state_e state, nxt;
  logic [WINDOW_W-1:0] left;
  logic [CNT_W-1:0] cnt, res_q;
  logic ovf, ovf_q, rise_in, rise_out;
  fo4_meas_sync #(.STAGES(SYNC_STAGES)) u_sync_in (
    .clk_i(clk_i), .reset_i(reset_i), .d(probe_in_i), .rise(rise_in)
  );
  fo4_meas_sync #(.STAGES(SYNC_STAGES)) u_sync_out (
    .clk_i(clk_i), .reset_i(reset_i), .d(probe_out_i), .rise(rise_out)
  );
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = en_i ? ARM : IDLE;
      ARM:   nxt = !en_i ? IDLE : (window_i == '0 ? DONE : COUNT);
      COUNT: nxt = !en_i ? IDLE : (left == WONE ? DONE : COUNT);
      DONE:  nxt = yumi_i ? (en_i ? ARM : IDLE) : DONE;
    endcase
  end
  // ovf is set exactly when cnt reaches MAX, so it doubles as the saturation flag
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      left <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (state == ARM) begin
        left <= window_i;
        cnt <= '0;
        ovf <= 1'b0;
      end
      if (state == COUNT) begin
        left <= left - WONE;
        if (rise_out && !ovf) begin
          cnt <= cnt + ONE;
          ovf <= (cnt == MAX - ONE);
        end
      end
      if (state == DONE) begin
        res_q <= cnt;
        ovf_q <= ovf;
      end
    end
  always_comb begin
    v_o = (state == DONE);
    result_o = v_o ? cnt : res_q;
    overflow_o = v_o ? ovf : ovf_q;
  end
`ifdef FO4_MEAS_DELAY_EN
  logic [CNT_W-1:0] dcnt, dres_q;
  logic d_run, d_hit;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      dcnt <= '0;
      dres_q <= '0;
      d_run <= 1'b0;
      d_hit <= 1'b0;
    end else begin
      if (state == ARM) begin
        dcnt <= '0;
        d_run <= 1'b0;
        d_hit <= 1'b0;
      end
      if (state == COUNT) begin
        if (d_run) begin
          dcnt <= (dcnt == MAX) ? MAX : dcnt + ONE;
          if (rise_out) begin
            d_run <= 1'b0;
            d_hit <= 1'b1;
          end
        end else if (!d_hit && rise_in) d_run <= 1'b1;
      end
      if (state == DONE) dres_q <= d_hit ? dcnt : MAX;
    end
  assign delay_o = v_o ? (d_hit ? dcnt : MAX) : dres_q;
`else
  logic unused_rise_in;
  assign unused_rise_in = rise_in;
`endif
endmodule
